// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer and its fetch FIFO.
package fetch_pkg;

    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush; the head is read straight from storage at the read pointer.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = logic [63:0]
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    entry_t      mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction memory,
// buffers {pc, inst} in a FIFO for decode, and handles redirects and out-of-window faults.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_W   = 13,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_en_i,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_pc_o,
    output logic              fault_o
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic         in_range;
    logic         attempt;
    logic         fire;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         unused_redirect_low;

    assign in_range = (pc_q[31:IMEM_W] == '0);
    assign attempt  = (state_q == RUN) && fetch_en_i && !redirect_valid_i;
    assign pop      = inst_valid_o && inst_ready_i;
    assign fire     = attempt && in_range && (!full || pop);

    assign push_entry = '{pc: pc_q, inst: imem_rdata_i};

    // Redirect targets are word aligned; the low address bits are dropped.
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en_i) state_d = RUN;
            RUN: begin
                if (!fetch_en_i)    state_d = IDLE;
                else if (!in_range) state_d = FAULT;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        if (redirect_valid_i) begin
            state_d = fetch_en_i ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect_valid_i) begin
                pc_q <= {redirect_pc_i[31:2], 2'b00};
            end else if (fire) begin
                pc_q <= pc_q + 32'(INSN_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (redirect_valid_i),
        .push  (fire),
        .pop   (pop),
        .wdata (push_entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign imem_addr_o  = pc_q[IMEM_W-1:0];
    assign inst_valid_o = !empty;
    assign inst_o       = head.inst;
    assign inst_pc_o    = head.pc;
    assign fault_o      = (state_q == FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: scoreboard of expected {pc, inst} plus per-scenario checks.
module tb_imem_fetch_ctrl;
    import fetch_pkg::*;

    localparam int unsigned IMEM_W   = 13;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned FQ_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_en = 1'b0;
    logic [IMEM_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              fault;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];

    imem_fetch_ctrl #(
        .IMEM_W   (IMEM_W),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fetch_en_i       (fetch_en),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .fault_o          (fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: word[i] = 0x100 + i.
    assign imem_rdata = 32'h100 + 32'(imem_addr >> 2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            fetch_entry_t e;
            e.pc   = start + 32'(4 * i);
            e.inst = 32'h100 + (e.pc >> 2);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every handshake must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got pc=%h inst=%h, required no output", inst_pc, inst);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    errors++;
                    $display("FAIL sb_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc, inst, e.pc, e.inst);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h, required 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, required 0", inst_pc); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b, required 0", fault); end
        checks++; if (imem_addr !== IMEM_W'(RESET_PC)) begin errors++; $display("FAIL reset_addr: got %h, required %h", imem_addr, IMEM_W'(RESET_PC)); end
        tick();
        tick();
    endtask

    task automatic test_stream();
        int n;
        push_stream(32'h0, 256);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        rst        = 1'b0;
        n = 0;
        while (inst_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_valid_timeout: got %b, required 1", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h100 + 32'(i) || inst_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b inst=%h pc=%h, required v=1 inst=%h pc=%h",
                         i, inst_valid, inst, inst_pc, 32'h100 + 32'(i), 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]       h;
        logic [IMEM_W-1:0] exp_addr;
        h = exp_q[0].pc;
        exp_addr = IMEM_W'(h + 32'd8);
        inst_ready = 1'b0;
        tick();
        tick();
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL bp_addr_early: got %h, required %h", imem_addr, exp_addr); end
        tick();
        tick();
        tick();
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL bp_addr_stall: got %h, required %h", imem_addr, exp_addr); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== h) begin errors++; $display("FAIL bp_head: got v=%b pc=%h, required v=1 pc=%h", inst_valid, inst_pc, h); end
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_resume_gap_%0d: got %b, required 1", i, inst_valid); end
        end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h41;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h40, 64);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b, required 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== 32'h110) begin
            errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h, required v=1 pc=00000040 inst=00000110", inst_valid, inst_pc, inst);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1FFC;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h1FFC, 1);
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1FFC || inst !== 32'h8FF) begin
            errors++; $display("FAIL fault_last_word: got v=%b pc=%h inst=%h, required v=1 pc=00001ffc inst=000008ff", inst_valid, inst_pc, inst);
        end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_early: got %b, required 0", fault); end
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b, required 1", fault); end
        checks++; if (imem_addr !== IMEM_W'(0)) begin errors++; $display("FAIL fault_addr: got %h, required 0", imem_addr); end
        tick();
        tick();
        tick();
        checks++; if (fault !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL fault_hold: got fault=%b v=%b, required fault=1 v=0", fault, inst_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h0, 64);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b, required 0", fault); end
        checks++; if (imem_addr !== IMEM_W'(0)) begin errors++; $display("FAIL fault_resume_addr: got %h, required 0", imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h100) begin
            errors++; $display("FAIL fault_resume: got v=%b pc=%h inst=%h, required v=1 pc=0 inst=00000100", inst_valid, inst_pc, inst);
        end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_fetch_pause();
        logic [31:0] h;
        int n;
        h = exp_q[0].pc;
        fetch_en = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL pause_drain: got %b, required 0", inst_valid); end
        checks++; if (imem_addr !== IMEM_W'(h + 32'd4)) begin errors++; $display("FAIL pause_pc_hold: got %h, required %h", imem_addr, IMEM_W'(h + 32'd4)); end
        fetch_en = 1'b1;
        n = 0;
        while (inst_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== h + 32'd4) begin
            errors++; $display("FAIL pause_resume: got v=%b pc=%h, required v=1 pc=%h", inst_valid, inst_pc, h + 32'd4);
        end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_async_reset();
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b, required 0", inst_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL areset_fault: got %b, required 0", fault); end
        checks++; if (imem_addr !== IMEM_W'(RESET_PC)) begin errors++; $display("FAIL areset_addr: got %h, required %h", imem_addr, IMEM_W'(RESET_PC)); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL areset_storage: got inst=%h pc=%h, required 0 0", inst, inst_pc); end
        exp_q.delete();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_fetch_pause();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
